// File: rtl/scpu_ctrl_pkg.sv
// Shared constants for the SCPU multi-cycle control path: opcode values,
// ALU operation classes, sequencer state encodings and a counter-width helper.
package scpu_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_BR    = 3'b001;
  localparam logic [2:0] ALUOP_R     = 3'b010;
  localparam logic [2:0] ALUOP_IMM   = 3'b011;
  localparam logic [2:0] ALUOP_LUI   = 3'b100;
  localparam logic [2:0] ALUOP_AUIPC = 3'b101;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_ERR    = 3'd6;

  // Wait-counter width able to hold 0..n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ctrl_class_dec.sv
// Opcode class decoder: maps the latched opcode to ALU controls and
// instruction-class flags. Unknown opcodes give aluop 000, alu_src 0, is_valid 0.
module ctrl_class_dec
  import scpu_ctrl_pkg::*;
(
  input  logic [6:0] opc,
  output logic [2:0] aluop,
  output logic       alu_src,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_valid
);

  // Pure table lookup on the opcode.
  always_comb begin
    aluop     = ALUOP_ADD;
    alu_src   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_valid  = 1'b1;
    case (opc)
      OP_R:      aluop = ALUOP_R;
      OP_LUI:    begin aluop = ALUOP_LUI;   alu_src = 1'b1; end
      OP_AUIPC:  begin aluop = ALUOP_AUIPC; alu_src = 1'b1; end
      OP_LOAD:   begin aluop = ALUOP_ADD;   alu_src = 1'b1; is_load  = 1'b1; end
      OP_IMM:    begin aluop = ALUOP_IMM;   alu_src = 1'b1; end
      OP_STORE:  begin aluop = ALUOP_ADD;   alu_src = 1'b1; is_store = 1'b1; end
      OP_BRANCH: begin aluop = ALUOP_BR;    is_branch = 1'b1; end
      default:   is_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the SCPU core with
// ready-based memory handshakes and a per-request wait timeout.
// Build option: define ILLEGAL_OP_TRAP_EN to trap unknown opcodes into ERR
// (sticky illegal_op); otherwise unknown opcodes retire as NOPs.
//
// state  | meaning
// IDLE   | after reset, outputs quiet, moves to FETCH next edge
// FETCH  | imem_req held until imem_ready; ir_write on the accepting cycle
// DECODE | opcode captured into opc_q
// EXEC   | ALU cycle; branches and NOPs retire here
// MEM    | dmem_req held until dmem_ready; stores retire here
// WB     | register writeback and retire
// ERR    | timeout or trapped opcode; left only through rst
module multicycle_ctrl_fsm
  import scpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  output logic       imem_req,
  input  logic       imem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic [2:0] aluop,
  output logic       alu_src,
  output logic       mem2reg,
  output logic       reg_write,
  output logic       retire,
  output logic       mem_err,
  output logic       illegal_op
);

  localparam int unsigned CNT_W = cnt_width(MEM_TIMEOUT);

  logic [2:0]       state, state_nxt;
  logic [6:0]       opc_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err_q;
  logic             req_wait, tmo_hit;
  logic [2:0]       dec_aluop;
  logic             dec_alu_src, is_load, is_store, is_branch, is_valid;

  ctrl_class_dec u_dec (
    .opc      (opc_q),
    .aluop    (dec_aluop),
    .alu_src  (dec_alu_src),
    .is_load  (is_load),
    .is_store (is_store),
    .is_branch(is_branch),
    .is_valid (is_valid)
  );

  // A request cycle without ready; the last allowed one is number MEM_TIMEOUT.
  assign req_wait = ((state == ST_FETCH) && !imem_ready) || ((state == ST_MEM) && !dmem_ready);
  assign tmo_hit  = (MEM_TIMEOUT != 0) && (32'(wait_cnt) == MEM_TIMEOUT - 1);

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = ST_FETCH;
      ST_FETCH:  if (imem_ready) state_nxt = ST_DECODE;
                 else if (tmo_hit) state_nxt = ST_ERR;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (!is_valid) begin
`ifdef ILLEGAL_OP_TRAP_EN
          state_nxt = ST_ERR;
`else
          state_nxt = ST_FETCH;
`endif
        end
        else if (is_load || is_store) state_nxt = ST_MEM;
        else if (is_branch)           state_nxt = ST_FETCH;
        else                          state_nxt = ST_WB;
      end
      ST_MEM:    if (dmem_ready) state_nxt = is_load ? ST_WB : ST_FETCH;
                 else if (tmo_hit) state_nxt = ST_ERR;
      ST_WB:     state_nxt = ST_FETCH;
      ST_ERR:    state_nxt = ST_ERR;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // State, opcode latch, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      opc_q     <= '0;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end
    else begin
      state <= state_nxt;
      if (state == ST_DECODE) opc_q <= opcode;
      // Any state change clears the count, which covers entry to FETCH and MEM.
      if (state_nxt != state) wait_cnt <= '0;
      else if (req_wait)      wait_cnt <= wait_cnt + CNT_W'(1);
      // Leaving FETCH or MEM for ERR can only be a timeout.
      if (((state == ST_FETCH) || (state == ST_MEM)) && (state_nxt == ST_ERR))
        mem_err_q <= 1'b1;
    end
  end

  assign mem_err = mem_err_q;

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q;

  // Sticky trap flag, set on the EXEC-to-ERR transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              illegal_q <= 1'b0;
    else if ((state == ST_EXEC) && (state_nxt == ST_ERR)) illegal_q <= 1'b1;
  end

  assign illegal_op = illegal_q;
`else
  assign illegal_op = 1'b0;
`endif

  // Control outputs from state and opc_q; handshake qualifiers use the ready inputs.
  always_comb begin
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_write  = 1'b0;
    branch    = 1'b0;
    aluop     = 3'b000;
    alu_src   = 1'b0;
    mem2reg   = 1'b0;
    reg_write = 1'b0;
    retire    = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      ST_EXEC: begin
        aluop   = dec_aluop;
        alu_src = dec_alu_src;
        if (is_branch) begin
          branch   = 1'b1;
          pc_write = 1'b1;
          retire   = 1'b1;
        end
`ifndef ILLEGAL_OP_TRAP_EN
        if (!is_valid) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
`endif
      end
      ST_MEM: begin
        aluop    = dec_aluop;
        alu_src  = dec_alu_src;
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (is_store && dmem_ready) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      ST_WB: begin
        aluop     = dec_aluop;
        alu_src   = dec_alu_src;
        reg_write = 1'b1;
        mem2reg   = is_load;
        pc_write  = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed + randomized bench for multicycle_ctrl_fsm with an instruction-level
// reference model (opcode class table, per-phase output expectations, latency formula).
module tb_multicycle_ctrl_fsm;

  localparam int TMO = 4;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [14:0] B_ILL  = 15'h0001;
  localparam logic [14:0] B_MERR = 15'h0002;
  localparam logic [14:0] B_RET  = 15'h0004;
  localparam logic [14:0] B_RW   = 15'h0008;
  localparam logic [14:0] B_M2R  = 15'h0010;
  localparam logic [14:0] B_BR   = 15'h0200;
  localparam logic [14:0] B_PC   = 15'h0400;
  localparam logic [14:0] B_WE   = 15'h0800;
  localparam logic [14:0] B_DREQ = 15'h1000;
  localparam logic [14:0] B_IRW  = 15'h2000;
  localparam logic [14:0] B_IREQ = 15'h4000;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3, K_BAD = 4;

  logic       clk, rst;
  logic [6:0] opcode;
  logic       imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic       ir_write, pc_write, branch, alu_src, mem2reg, reg_write, retire;
  logic       mem_err, illegal_op;
  logic [2:0] aluop;
  logic [14:0] obs;

  int total = 0;
  int bad   = 0;
  int cyc;
  int ret_cyc;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
    .aluop(aluop), .alu_src(alu_src), .mem2reg(mem2reg), .reg_write(reg_write),
    .retire(retire), .mem_err(mem_err), .illegal_op(illegal_op)
  );

  assign obs = {imem_req, ir_write, dmem_req, dmem_we, pc_write, branch,
                aluop, alu_src, mem2reg, reg_write, retire, mem_err, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Opcode class table straight from the instruction-set description.
  function automatic void model(input logic [6:0] op, output int kind,
                                output logic [2:0] aop, output logic src);
    kind = K_ALU; aop = 3'b000; src = 1'b0;
    case (op)
      7'b0110011: begin aop = 3'b010; src = 1'b0; end
      7'b0110111: begin aop = 3'b100; src = 1'b1; end
      7'b0010111: begin aop = 3'b101; src = 1'b1; end
      7'b0000011: begin aop = 3'b000; src = 1'b1; kind = K_LOAD; end
      7'b0010011: begin aop = 3'b011; src = 1'b1; end
      7'b0100011: begin aop = 3'b000; src = 1'b1; kind = K_STORE; end
      7'b1100011: begin aop = 3'b001; src = 1'b0; kind = K_BRANCH; end
      default:    kind = K_BAD;
    endcase
  endfunction

  task automatic chk(input logic [14:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Inputs are already set; check mid-cycle, then advance to just after the edge.
  task automatic step(input logic [14:0] exp, input string tag);
    @(negedge clk);
    chk(exp, tag);
    cyc++;
    if (retire === 1'b1 && ret_cyc < 0) ret_cyc = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk(15'h0, "rst_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(15'h0, "idle");
  endtask

  task automatic err_tail(input logic [14:0] exp, input string tag);
    for (int k = 0; k < 3; k++) begin
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      opcode     = 7'($urandom);
      step(exp, tag);
    end
  endtask

  // Runs one instruction from the first FETCH cycle; iw/dw are wait cycles before ready.
  task automatic run_instr(input logic [6:0] op, input int iw, input int dw,
                           input int abort_at, input string tag);
    int kind, lat;
    logic [2:0] aop;
    logic src;
    logic [14:0] af, e;
    model(op, kind, aop, src);
    af = {6'b0, aop, src, 5'b0};
    cyc = 0;
    ret_cyc = -1;
    for (int k = 0; k < TMO; k++) begin
      imem_ready = (k == iw);
      dmem_ready = 1'($urandom);
      opcode     = (k == iw) ? op : 7'($urandom);
      step(B_IREQ | ((k == iw) ? B_IRW : 15'h0), {tag, ".fetch"});
      if (k == iw) break;
    end
    if (iw >= TMO) begin
      err_tail(B_MERR, {tag, ".err"});
      return;
    end
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    step(15'h0, {tag, ".dec"});
    opcode = 7'($urandom);
    if (kind == K_BAD && TRAP) begin
      step(15'h0, {tag, ".exec"});
      err_tail(B_ILL, {tag, ".trap"});
      return;
    end
    e = af;
    if (kind == K_BRANCH) e = e | B_BR | B_PC | B_RET;
    if (kind == K_BAD)    e = e | B_PC | B_RET;
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    step(e, {tag, ".exec"});
    if (kind == K_LOAD || kind == K_STORE) begin
      for (int k = 0; k < TMO; k++) begin
        if (k == abort_at) begin
          dmem_ready = 1'b0;
          #2;
          rst = 1'b1;
          #1;
          chk(15'h0, {tag, ".abort"});
          @(posedge clk);
          #1;
          rst = 1'b0;
          step(15'h0, {tag, ".idle"});
          return;
        end
        dmem_ready = (k == dw);
        imem_ready = 1'($urandom);
        e = af | B_DREQ;
        if (kind == K_STORE) e = e | B_WE;
        if (kind == K_STORE && k == dw) e = e | B_PC | B_RET;
        step(e, {tag, ".mem"});
        if (k == dw) break;
      end
      if (dw >= TMO) begin
        err_tail(B_MERR, {tag, ".err"});
        return;
      end
    end
    if (kind == K_ALU || kind == K_LOAD) begin
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      step(af | B_RW | B_PC | B_RET | ((kind == K_LOAD) ? B_M2R : 15'h0), {tag, ".wb"});
    end
    case (kind)
      K_LOAD:   lat = 5 + iw + dw;
      K_STORE:  lat = 4 + iw + dw;
      K_BRANCH: lat = 3 + iw;
      K_BAD:    lat = 3 + iw;
      default:  lat = 4 + iw;
    endcase
    total++;
    assert (ret_cyc === lat) else begin
      bad++;
      $error("FAIL %s.latency got=%0d exp=%0d", tag, ret_cyc, lat);
    end
  endtask

  logic [6:0] ops [8];

  initial begin
    ops[0] = 7'b0110011; ops[1] = 7'b0110111; ops[2] = 7'b0010111; ops[3] = 7'b0000011;
    ops[4] = 7'b0010011; ops[5] = 7'b0100011; ops[6] = 7'b1100011; ops[7] = 7'b1111111;
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    opcode = 7'h0;
    do_reset();

    run_instr(7'b0110011, 0, 0, -1, "r_zero");
    run_instr(7'b0000011, 0, 3, -1, "load_d3");
    run_instr(7'b0100011, 0, 0, -1, "store");
    run_instr(7'b1100011, 0, 0, -1, "branch");
    run_instr(7'b0010011, TMO - 1, 0, -1, "imm_iw_max");
    run_instr(7'b0100011, 1, TMO - 1, -1, "store_dw_max");
    run_instr(7'b0110111, 2, 0, -1, "lui");
    run_instr(7'b0010111, 0, 0, -1, "auipc");
    run_instr(7'b0000011, 1, 5, 2, "load_abort");
    run_instr(7'b0000011, 0, 0, -1, "load_after_abort");

    for (int n = 0; n < 30; n++) begin
      int idx;
      idx = TRAP ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 7));
      run_instr(ops[idx], int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, TMO - 1)),
                -1, "rand");
    end

    run_instr(7'b1111111, 0, 0, -1, "unknown_op");
    if (TRAP) do_reset();

    run_instr(7'b0110011, TMO, 0, -1, "imem_tmo");
    do_reset();
    run_instr(7'b0000011, 0, TMO, -1, "dmem_tmo");
    do_reset();
    run_instr(7'b0100011, 0, 1, -1, "store_after_err");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
